muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide controller for the MIPS EX stage. It owns the architectural HI/LO registers and executes MULT, MULTU, DIV and DIVU as a 32-iteration shift-add or restoring-divide sequence, with a 33-bit add/sub step alongside the single-cycle ALU. It also services MTHI/MTLO writes. It raises a stall to the pipeline when MFHI/MFLO reads HI/LO while an operation is in flight.

## Interface
- `XLEN`, default 32: operand width. Only 32 is supported.
- `ITER`, default 32: iterations per mul/div. Must equal `XLEN`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  operation request from EX, valid for one cycle.
- `op`  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Other codes are ignored.
- `rs_val`  in  32  multiplicand or dividend; source for MTHI/MTLO.
- `rt_val`  in  32  multiplier or divisor.
- `flush`  in  1  pipeline flush; aborts any in-flight operation.
- `mf_req`  in  1  MFHI/MFLO in EX.
- `busy`  out  1  mul/div in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold a new mul/div result.
- `stall`  out  1  `mf_req && busy`, combinational.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE to RUN on `start` with a mul/div op and no `flush`.
  - RUN to FIX when the iteration counter reaches `ITER-1`.
  - FIX to IDLE unconditionally.
- IDLE + `start`:
  - Latch operand magnitudes, result signs and op.
  - Clear the 6-bit counter.
- MTHI/MTLO in IDLE: write `rs_val` to `hi`/`lo` at the next edge. `busy` and `done` are not asserted.
- Multiply, per RUN cycle:
  - If the accumulator LSB of the multiplier is 1, do a 33-bit add of the multiplicand into the upper half.
  - Shift the 64-bit {acc, multiplier} right by 1.
- Divide, per RUN cycle (restoring):
  - Shift {rem, quot} left by 1.
  - Form the 33-bit trial `rem - divisor`.
  - If the trial is non-negative, keep it and set the quotient LSB; otherwise restore.
- FIX:
  - Apply sign correction by two's-complement negation.
  - Product: negate the 64-bit result if the operand signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Write `hi`/`lo` at the end of FIX.
- Divide by zero (divisor == 0, signed or unsigned): `lo` = 0xFFFFFFFF, `hi` = `rs_val`. The full latency still applies.
- Signed overflow 0x80000000 / -1: `lo` = 0x80000000, `hi` = 0.
- `start` while `busy`: ignored. The pipeline must hold via hazard logic.
- MTHI/MTLO while `busy`: ignored.
- `flush` in any state:
  - Next state is IDLE.
  - Counter is cleared.
  - `hi`/`lo` are unchanged and no `done` is raised.
  - `flush` overrides a same-cycle `start`.
- Reset: state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, counter 0.
- Reset asserted mid-operation: the operation is abandoned and all of the above values apply immediately.

## Timing
- `start` sampled at edge T:
  - `busy` = 1 during cycles T+1..T+33 (32 RUN cycles + 1 FIX cycle).
  - `hi`/`lo` update at the edge ending cycle T+33.
  - `done` = 1 during cycle T+34 only; `busy` = 0 in that cycle.
- Total latency: 34 cycles from `start` to `done`.
- Back-to-back operations: `start` is accepted in the `done` cycle.
- `stall` is combinational and deasserts in the `done` cycle, so MFHI in that cycle reads the new value.
- MTHI/MTLO: 1-cycle write; the new value is visible the cycle after `start`.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT and DIV use signed semantics: magnitude conversion at start, negation in FIX.
- Undefined:
  - MULT and DIV execute as MULTU and DIVU.
  - Sign latches and negation logic are removed.
  - FIX remains a one-cycle state, so latency is unchanged at 34 cycles.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings;
  - the state enum (IDLE, RUN, FIX);
  - `XLEN` and `ITER` constants.
- One sub-module, `muldiv_step`: combinational 33-bit add/sub plus shift for one iteration, selected by a mul/div flag. It is instantiated once.
- The controller holds the FSM, counter, operand latches, sign fix-up and the HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `done` exactly at T+34; `busy` high T+1..T+33.
- MULT -3 × 7 (signed build): `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- DIV -7 / 2 (signed build): `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - Unsigned build: `lo` = 0x7FFFFFFC, `hi` = 0x00000001.
- DIVU 0x64 / 0: `lo` = 0xFFFFFFFF, `hi` = 0x00000064 after 34 cycles.
- MULTU started with prior `hi`/`lo` = 0xAAAA/0x5555, `flush` at T+10:
  - `busy` = 0 from T+11;
  - `hi`/`lo` stay 0xAAAA/0x5555;
  - no `done`;
  - a new `start` at T+12 completes normally.
- `mf_req` held during DIVU: `stall` high T+1..T+33, low at T+34.
- MTLO 0x1234 in IDLE: `lo` = 0x1234 next cycle with no `done`.
- `rst_n` low at T+20: all outputs zero immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide controller: op codes,
// FSM states, operand width and iteration count.
package muldiv_pkg;

    localparam int MD_XLEN = 32;
    localparam int MD_ITER = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic [MD_XLEN-1:0] neg32(input logic [MD_XLEN-1:0] v);
        return ~v + {{(MD_XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*MD_XLEN-1:0] neg64(input logic [2*MD_XLEN-1:0] v);
        return ~v + {{(2*MD_XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide, built around a
// single 33-bit adder that subtracts (invert + carry-in) in divide mode.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            i_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opb,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0] w_a;
    logic [XLEN:0] w_b;
    logic [XLEN:0] w_sum;
    logic          w_cin;

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_cin = 1'b0;
        o_hi  = '0;
        o_lo  = '0;
        if (i_div) begin
            // The remainder stays below the divisor, so bit 32 of the trial is its sign.
            w_a   = {i_hi, i_lo[XLEN-1]};
            w_b   = ~{1'b0, i_opb};
            w_cin = 1'b1;
        end else begin
            w_a   = {1'b0, i_hi};
            w_b   = i_lo[0] ? {1'b0, i_opb} : '0;
        end
        w_sum = w_a + w_b + {{XLEN{1'b0}}, w_cin};
        if (i_div) begin
            if (!w_sum[XLEN]) begin
                o_hi = w_sum[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b1};
            end else begin
                o_hi = w_a[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[XLEN:1];
            o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS HI/LO multiply/divide controller: 32 RUN cycles plus one FIX cycle.
// Signed MULT/DIV are enabled by defining MULDIV_SIGNED_EN; otherwise they run unsigned.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN,
    parameter int ITER = MD_ITER
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    input  logic            mf_req,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e            r_state;
    state_e            w_next;
    logic [5:0]        r_cnt;
    logic              r_done;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_qlo;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_dvd;
    logic              r_div;
    logic              r_dvz;

    logic              w_idle;
    logic              w_md_start;
    logic              w_mt;
    logic              w_fix_wr;
    logic [XLEN-1:0]   w_rs_mag;
    logic [XLEN-1:0]   w_rt_mag;
    logic              w_neg_q;
    logic              w_neg_r;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_md_start = w_idle && start && !flush && !op[2];
    assign w_mt       = w_idle && start && !flush && (op == OP_MTHI || op == OP_MTLO);
    assign w_fix_wr   = (r_state == ST_FIX) && !flush;

`ifdef MULDIV_SIGNED_EN
    logic w_sgn;
    logic r_neg_q;
    logic r_neg_r;

    assign w_sgn    = !op[0];
    assign w_rs_mag = (w_sgn && rs_val[XLEN-1]) ? neg32(rs_val) : rs_val;
    assign w_rt_mag = (w_sgn && rt_val[XLEN-1]) ? neg32(rt_val) : rt_val;
    assign w_neg_q  = r_neg_q;
    assign w_neg_r  = r_neg_r;

    always_ff @(posedge clk) begin
        if (w_md_start) begin
            r_neg_q <= w_sgn && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            r_neg_r <= w_sgn && rs_val[XLEN-1];
        end
    end
`else
    assign w_rs_mag = rs_val;
    assign w_rt_mag = rt_val;
    assign w_neg_q  = 1'b0;
    assign w_neg_r  = 1'b0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_div (r_div),
        .i_hi  (r_acc),
        .i_lo  (r_qlo),
        .i_opb (r_opb),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );

    // Sign fix-up; the remainder follows the dividend's sign.
    assign w_prod = w_neg_q ? neg64({r_acc, r_qlo}) : {r_acc, r_qlo};
    assign w_quot = w_neg_q ? neg32(r_qlo) : r_qlo;
    assign w_rem  = w_neg_r ? neg32(r_acc) : r_acc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_md_start) w_next = ST_RUN;
            ST_RUN:  if (r_cnt == 6'(ITER-1)) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fix_wr;
            if (flush || r_state != ST_RUN) r_cnt <= '0;
            else                            r_cnt <= r_cnt + 6'd1;
            if (w_fix_wr) begin
                if (!r_div) begin
                    {r_hi, r_lo} <= w_prod;
                end else if (r_dvz) begin
                    r_hi <= r_dvd;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end
            end else if (w_mt) begin
                if (op == OP_MTHI) r_hi <= rs_val;
                else               r_lo <= rs_val;
            end
        end
    end

    // Working registers: the multiplier/dividend shifts through r_qlo.
    always_ff @(posedge clk) begin
        if (w_md_start) begin
            r_div <= op[1];
            r_dvz <= (rt_val == '0);
            r_dvd <= rs_val;
            r_acc <= '0;
            if (op[1]) begin
                r_qlo <= w_rs_mag;
                r_opb <= w_rt_mag;
            end else begin
                r_qlo <= w_rt_mag;
                r_opb <= w_rs_mag;
            end
        end else if (r_state == ST_RUN) begin
            r_acc <= w_step_hi;
            r_qlo <= w_step_lo;
        end
    end

    assign busy  = !w_idle;
    assign done  = r_done;
    assign stall = mf_req && busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        mf_req = 1'b0;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] C_MULT = 3'b000, C_MULTU = 3'b001, C_DIV = 3'b010,
                           C_DIVU = 3'b011, C_MTHI = 3'b100, C_MTLO = 3'b101;

`ifdef MULDIV_SIGNED_EN
    localparam logic [63:0] E_MULT   = 64'hFFFFFFFF_FFFFFFEB;
    localparam logic [63:0] E_DIV_A  = 64'hFFFFFFFF_FFFFFFFD;
    localparam logic [63:0] E_DIV_B  = 64'h00000001_FFFFFFFD;
    localparam logic [63:0] E_OVF    = 64'h00000000_80000000;
`else
    localparam logic [63:0] E_MULT   = 64'h00000006_FFFFFFEB;
    localparam logic [63:0] E_DIV_A  = 64'h00000001_7FFFFFFC;
    localparam logic [63:0] E_DIV_B  = 64'h00000007_00000000;
    localparam logic [63:0] E_OVF    = 64'h80000000_00000000;
`endif

    muldiv_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .mf_req (mf_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Starts an op and watches 40 cycles; k counts cycles after the sampling edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic mf, output int busy_n, output int stall_n,
                          output int done_at, output int done_n);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b; mf_req = mf;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; stall_n = 0; done_at = 0; done_n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (busy)  busy_n++;
            if (stall) stall_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
        end
        mf_req = 1'b0;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic md_case(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int bn, sn, da, dn;
        run_op(o, a, b, 1'b0, bn, sn, da, dn);
        chk({tag, "_hilo"}, {hi, lo}, exp);
        chk({tag, "_done_at"}, 64'(da), 64'd34);
    endtask

    initial begin
        int bn, sn, da, dn;
        #1;
        chk("reset_outs", {30'd0, busy, done, hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, bn, sn, da, dn);
        chk("multu_max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        chk("multu_done_at", 64'(da), 64'd34);
        chk("multu_done_cnt", 64'(dn), 64'd1);
        chk("multu_busy_cycles", 64'(bn), 64'd33);

        md_case("mult_m3x7", C_MULT, 32'hFFFFFFFD, 32'd7, E_MULT);
        md_case("div_m7d2", C_DIV, 32'hFFFFFFF9, 32'd2, E_DIV_A);
        md_case("div_7dm2", C_DIV, 32'd7, 32'hFFFFFFFE, E_DIV_B);
        md_case("div_ovf", C_DIV, 32'h80000000, 32'hFFFFFFFF, E_OVF);
        md_case("divu_100d7", C_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});

        run_op(C_DIVU, 32'h64, 32'h0, 1'b1, bn, sn, da, dn);
        chk("divu_by0_hilo", {hi, lo}, 64'h00000064_FFFFFFFF);
        chk("divu_by0_done_at", 64'(da), 64'd34);
        chk("stall_cycles", 64'(sn), 64'd33);

        mt(C_MTHI, 32'hAAAA);
        chk("mthi_hi", {32'd0, hi}, 64'hAAAA);
        mt(C_MTLO, 32'h5555);
        chk("mtlo_lo", {32'd0, lo}, 64'h5555);
        chk("mtlo_no_busy_done", {62'd0, busy, done}, 64'd0);

        // Flush at T+10 with an ignored MTLO attempted while busy.
        @(negedge clk);
        start = 1'b1; op = C_MULTU; rs_val = 32'd3; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) begin
                op = C_MTLO; rs_val = 32'hDEAD;
            end
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hilo_kept", {hi, lo}, 64'h0000AAAA_00005555);
        run_op(C_MULTU, 32'd6, 32'd7, 1'b0, bn, sn, da, dn);
        chk("after_flush_hilo", {hi, lo}, 64'd42);
        chk("after_flush_done_at", 64'(da), 64'd34);
        chk("after_flush_done_cnt", 64'(dn), 64'd1);

        mt(C_MTLO, 32'h1234);
        chk("mtlo_1234", {32'd0, lo}, 64'h1234);
        chk("mtlo_1234_done", {63'd0, done}, 64'd0);

        // Reset asserted at T+20 of a running operation.
        @(negedge clk);
        start = 1'b1; op = C_MULTU; rs_val = 32'hFFFFFFFF; rt_val = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_op", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
